// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit register where every bit has its own J/K pair, plus
// whole-word modes (load, shift left/right, count up/down, complement).
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset; wins over en_i and mode_i
//   en_i       clock enable; 0 holds q, q_barra and co
//   mode_i     operation select:
//              000 HOLD, 001 JK, 010 LOAD, 011 SHL,
//              100 SHR, 101 INC, 110 DEC, 111 CPL
//   j_i, k_i   per-bit J/K inputs (JK mode only)
//   d_i        parallel load data (LOAD mode only)
//   ser_in_i   serial input bit for the shift modes
//   q_o        register value
//   q_barra_o  registered complement of q_o, always in step with it
//   co_o       registered carry / borrow / shift-out flag
//   zero_o     combinational, 1 when q_o is zero
module jk_reg_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] j_i,
    input  logic [WIDTH-1:0] k_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_barra_o,
    output logic             co_o,
    output logic             zero_o
);

    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeJk   = 3'b001,
        ModeLoad = 3'b010,
        ModeShl  = 3'b011,
        ModeShr  = 3'b100,
        ModeInc  = 3'b101,
        ModeDec  = 3'b110,
        ModeCpl  = 3'b111
    } mode_e;

    // Declaration initialisers give the power-up state on targets that honour them.
    logic [WIDTH-1:0] q_q       = RESET_VAL;
    logic [WIDTH-1:0] q_barra_q = ~RESET_VAL;
    logic             co_q      = 1'b0;

    logic [WIDTH-1:0] q_d;
    logic             co_d;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;

    // One extra bit catches the wrap: carry out of INC, borrow out of DEC.
    assign inc_sum  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        q_d  = q_q;
        co_d = co_q;
        if (en_i) begin
            case (mode_e'(mode_i))
                ModeHold: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
                ModeJk: begin
                    // Per bit: set where j=1 and q=0, keep where k=0 and q=1.
                    q_d = (j_i & ~q_q) | (~k_i & q_q);
                end
                ModeLoad: begin
                    q_d  = d_i;
                    co_d = 1'b0;
                end
                ModeShl: begin
                    q_d  = {q_q[WIDTH-2:0], ser_in_i};
                    co_d = q_q[WIDTH-1];
                end
                ModeShr: begin
                    q_d  = {ser_in_i, q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                ModeInc: begin
                    q_d  = inc_sum[WIDTH-1:0];
                    co_d = inc_sum[WIDTH];
                end
                ModeDec: begin
                    q_d  = dec_diff[WIDTH-1:0];
                    co_d = dec_diff[WIDTH];
                end
                ModeCpl: begin
                    q_d  = ~q_q;
                    co_d = 1'b0;
                end
                default: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
            endcase
        end
    end

    // q and q_barra share one block so they can never be out of step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q       <= RESET_VAL;
            q_barra_q <= ~RESET_VAL;
            co_q      <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_barra_q <= ~q_d;
            co_q      <= co_d;
        end
    end

    assign q_o       = q_q;
    assign q_barra_o = q_barra_q;
    assign co_o      = co_q;
    assign zero_o    = (q_q == '0);

endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised successor to the team's single-bit JK flip-flop.
- Implements a WIDTH-bit register in which every bit has its own J/K pair, plus whole-word modes: parallel load, shift left/right, count up/down, and complement.
- Used by the processor datapath as a general-purpose register, counter or shifter.
- Provides complementary outputs and a registered carry/shift-out flag.

Parameters:
- WIDTH, 8, number of bits in the register (must be at least 2).
- RESET_VAL, 0, value loaded into q at reset and at power-up; sized to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  3  operation select (see Behaviour).
- j  input  WIDTH  per-bit J inputs, used only in mode 001.
- k  input  WIDTH  per-bit K inputs, used only in mode 001.
- d  input  WIDTH  parallel load data, used only in mode 010.
- ser_in  input  1  serial input bit for the shift modes.
- q  output  WIDTH  register value.
- q_barra  output  WIDTH  always equal to the bitwise complement of q; registered, never out of step with q.
- co  output  1  registered carry, borrow or shift-out flag.
- zero  output  1  combinational; 1 when q equals 0.

Behaviour:
- Power-up: q=RESET_VAL, q_barra=~RESET_VAL, co=0.
- Reset: one clk edge with rst=1 gives q=RESET_VAL, q_barra=~RESET_VAL, co=0.
  - rst overrides en and mode.
  - Asserting rst mid-count or mid-shift discards the operation in that cycle.
- en=0 and rst=0: q, q_barra and co all hold.
- en=1: the rising edge applies mode; the result is visible 1 cycle later.
- Modes:
  - 000 HOLD: q and co unchanged.
  - 001 JK: each bit i follows the JK rule independently, co unchanged.
    - j=0, k=0: hold.
    - j=0, k=1: clear to 0.
    - j=1, k=0: set to 1.
    - j=1, k=1: toggle.
  - 010 LOAD: q=d, co=0.
  - 011 SHL: q={q[WIDTH-2:0], ser_in}, co=old q[WIDTH-1].
  - 100 SHR: q={ser_in, q[WIDTH-1:1]}, co=old q[0].
  - 101 INC: q=q+1 modulo 2^WIDTH.
    - co=1 only when old q was all ones (wraps to 0); otherwise co=0.
  - 110 DEC: q=q-1 modulo 2^WIDTH.
    - co=1 only when old q was 0 (wraps to all ones); otherwise co=0.
  - 111 CPL: q=~q, co=0.
- Arithmetic is unsigned at WIDTH bits; no saturation.
- q_barra is updated in the same always block as q; there is no cycle in which q_barra != ~q.
- zero is derived combinationally from q, so it reflects q in the same cycle.
- Undefined (X) mode values are not required to be handled beyond simulation; synthesis treats them as HOLD.

Test Plan (WIDTH=8, RESET_VAL=0):
1. Power-up, then rst=1 for 1 edge with mode=101, en=1 -> q=0x00, q_barra=0xFF, co=0, zero=1. Reset wins over INC.
2. LOAD d=0xA5, then JK with j=0x0F, k=0xF0 -> q=0x0F. Then JK with j=0xFF, k=0xFF -> q=0xF0, q_barra=0x0F.
3. LOAD 0xFE, then INC x2 -> q=0xFF with co=0, then q=0x00 with co=1 and zero=1. Then DEC -> q=0xFF, co=1. Then DEC -> q=0xFE, co=0.
4. LOAD 0x81, SHL with ser_in=0 -> q=0x02, co=1. Then SHR with ser_in=1 -> q=0x81, co=0. Then SHR with ser_in=0 -> q=0x40, co=1.
5. LOAD 0x3C, then en=0 for 3 edges with mode=111 -> q stays 0x3C and co is unchanged. Then en=1 with CPL -> q=0xC3, q_barra=0x3C, co=0.
6. Counting 0x10 via INC, assert rst on the next edge -> q=0x00, co=0. Release rst and INC -> q=0x01.
